dmem_mmio_responder: RTL

- Target end of the CPU data-memory port. Accepts daddr/dwdata/dwe from the single-cycle core and returns drdata.
- Contains a word-organised data RAM with byte-lane writes.
- Contains a small MMIO region:
  - free-running 64-bit cycle counter;
  - console TX FIFO drained through a valid/ready byte stream;
  - status/overflow register.
- Sits beside the core at top level, in place of a plain DMEM model.

---
 rtl/dmem_mmio_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_mmio_responder -- data RAM with byte lanes plus an MMIO page
//          holding a 64-bit cycle counter, console TX FIFO and status register.
// Rev    : 1.0
// ============================================================================
module dmem_mmio_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready
);

  localparam int                 c_RAM_AW     = $clog2(RAM_WORDS);
  localparam int                 c_FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam logic [32:0]        c_RAM_BYTES  = 33'(RAM_WORDS) << 2;
  localparam logic [c_FIFO_AW:0] c_FULL_COUNT = (c_FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [c_FIFO_AW:0] c_CNT_ONE    = (c_FIFO_AW + 1)'(1);
  localparam logic [c_FIFO_AW-1:0] c_PTR_ONE  = c_FIFO_AW'(1);
  localparam logic [1:0]         c_REG_LO     = 2'd0;
  localparam logic [1:0]         c_REG_HI     = 2'd1;
  localparam logic [1:0]         c_REG_TX     = 2'd2;
  localparam logic [1:0]         c_REG_STATUS = 2'd3;

  logic [31:0]          r_ram [RAM_WORDS];
  logic [7:0]           r_fifo [FIFO_DEPTH];
  logic [63:0]          r_cycle;
  logic [c_FIFO_AW-1:0] r_rd_ptr;
  logic [c_FIFO_AW-1:0] r_wr_ptr;
  logic [c_FIFO_AW:0]   r_count;
  logic                 r_overflow;

  logic [29:0]          w_mmio_woff;
  logic                 w_ram_sel;
  logic                 w_mmio_sel;
  logic [1:0]           w_mmio_reg;
  logic [c_RAM_AW-1:0]  w_ram_idx;
  logic                 w_push_req;
  logic                 w_push_ok;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_ovf_clr;
  logic                 w_full;
  logic                 w_empty;
  logic [7:0]           w_count8;
  logic [31:0]          w_status;
  logic                 w_unused_addr;

  // Word-granular decode; the byte offset inside a word is ignored.
  assign w_unused_addr = ^daddr[1:0];
  assign w_mmio_woff   = daddr[31:2] - MMIO_BASE[31:2];
  assign w_ram_sel     = ({1'b0, daddr} < c_RAM_BYTES);
  assign w_mmio_sel    = (w_mmio_woff[29:2] == 28'd0);
  assign w_mmio_reg    = w_mmio_woff[1:0];
  assign w_ram_idx     = daddr[c_RAM_AW+1:2];

  assign w_full        = (r_count == c_FULL_COUNT);
  assign w_empty       = (r_count == '0);
  assign console_valid = !w_empty;
  assign console_data  = console_valid ? r_fifo[r_rd_ptr] : 8'd0;

  assign w_pop      = console_valid && console_ready;
  assign w_push_req = !w_ram_sel && w_mmio_sel && (w_mmio_reg == c_REG_TX) && dwe[0];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push_ok;
  assign w_ovf_clr  = !w_ram_sel && w_mmio_sel && (w_mmio_reg == c_REG_STATUS)
                      && dwe[2] && dwdata[16];

  assign w_count8 = 8'(r_count);
  assign w_status = {15'd0, r_overflow, 4'd0, w_count8, 2'd0, w_empty, w_full};

  always_ff @(posedge clk) begin
    if (!reset && w_ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) r_ram[w_ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) r_fifo[r_wr_ptr] <= dwdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_push_ok && !w_pop)      r_count <= r_count + c_CNT_ONE;
      else if (w_pop && !w_push_ok) r_count <= r_count - c_CNT_ONE;
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    drdata = 32'd0;
    if (w_ram_sel) begin
      drdata = r_ram[w_ram_idx];
    end else if (w_mmio_sel) begin
      case (w_mmio_reg)
        c_REG_LO:     drdata = r_cycle[31:0];
        c_REG_HI:     drdata = r_cycle[63:32];
        c_REG_STATUS: drdata = w_status;
        default:      drdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire
